// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage RV32I pipeline.
//
// Owns the program counter and the IF/ID pipeline latch. The PC drives the
// instruction-memory address combinationally; the returned word is captured
// into IF/ID together with the PC and PC+4 on the next rising edge.
//
// Per-edge priority: redirect > stall > advance.
//
// Optional feature (compile-time macro IF_MISALIGN_CHK_EN):
//   adds output misalign_err, a sticky flag set by any redirect whose target
//   has non-zero low two bits. Without the macro those bits are silently
//   dropped and the port does not exist.
//
// ifid_valid semantics: ifid_valid=1 means IF/ID holds a real fetched
// instruction that decode may consume. There is no ready input; the hazard
// unit's stall acts as the back-pressure and freezes the latch. When
// ifid_valid=0 the latch always carries NOP_INST with ifid_pc/ifid_pc4 at 0.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic [31:0]     ifid_inst,
    output logic            ifid_valid
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic            misalign_err
`endif
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_aligned;

    // Sequential-fetch increment and word-aligned redirect target.
    always_comb begin
        pc_plus4         = pc + XLEN'(4);
        redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    end

    assign imem_addr = pc;

    // Program counter: redirect wins, stall holds, otherwise step by 4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_aligned;
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID latch: redirect kills the wrong-path slot even when stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pc    <= '0;
            ifid_pc4   <= '0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (redirect) begin
            ifid_pc    <= '0;
            ifid_pc4   <= '0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_pc    <= pc;
            ifid_pc4   <= pc_plus4;
            ifid_inst  <= imem_rdata;
            ifid_valid <= 1'b1;
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule
